// File: rtl/pipe_flow_ctrl.sv
`default_nettype none
// pipe_flow_ctrl: valid/ready to single-clken flow control for a fixed-latency sfr_ce pipeline. Rev 1.0
// Optional drain state machine is built when PIPE_FLOW_FLUSH_EN is defined.
module pipe_flow_ctrl #(
  parameter int  LATENCY    = 4,
  parameter int  WIDTH      = 24,
  parameter int  FIFO_DEPTH = 2,
  localparam int OCC_W      = $clog2(LATENCY + FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_last,
  output logic             pipe_clken,
  input  logic [WIDTH-1:0] pipe_data_out,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [OCC_W-1:0] occupancy,
  input  logic             flush,
  output logic             flush_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [LATENCY-1:0] vld;
  logic [LATENCY-1:0] lst;
  logic [PTR_W:0]     wr_ptr;
  logic [PTR_W:0]     rd_ptr;
  logic [WIDTH:0]     mem [FIFO_DEPTH];
  logic [WIDTH:0]     head;
  logic               fifo_empty;
  logic               fifo_full;
  logic               accept;
  logic               push;
  logic               pop;
  logic               run;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // Enable is a function of registers (and reset) only, never of m_ready/s_valid.
  assign pipe_clken = aresetn & ~(vld[LATENCY-1] & fifo_full);
  assign s_ready    = pipe_clken & run;
  assign accept     = s_valid & s_ready;
  assign push       = pipe_clken & vld[LATENCY-1];
  assign pop        = m_valid & m_ready;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      vld <= '0;
      lst <= '0;
    end else if (pipe_clken) begin
      vld[0] <= accept;
      lst[0] <= accept & s_last;
      for (int i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1];
        lst[i] <= lst[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PTR_W-1:0]] <= {pipe_data_out, lst[LATENCY-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + {{PTR_W{1'b0}}, push};
      rd_ptr <= rd_ptr + {{PTR_W{1'b0}}, pop};
    end
  end

  // Unwritten entries are masked so nothing stale is ever visible at the head.
  assign head    = mem[rd_ptr[PTR_W-1:0]];
  assign m_valid = ~fifo_empty;
  assign m_data  = m_valid ? head[WIDTH:1] : '0;
  assign m_last  = m_valid & head[0];

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      occupancy <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

`ifdef PIPE_FLOW_FLUSH_EN
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    run        = 1'b0;
    flush_done = 1'b0;
    case (state)
      ST_RUN: begin
        run = 1'b1;
        if (flush) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (occupancy == '0) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        flush_done = aresetn;
        state_nxt  = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end
`else
  logic unused_flush;

  assign run          = 1'b1;
  assign flush_done   = 1'b0;
  assign unused_flush = flush;
`endif

endmodule
`default_nettype wire
